// File: rtl/done_gated_reset_counter_pkg.sv
// ----------------------------------------------------------------------------
// done_gated_reset_counter_pkg
//   Shared constants for the done-gated reset / cycle counter block.
//   Defaults and legal ranges for the top-level parameters live here so that
//   integration code can reference the same values the block uses.
// ----------------------------------------------------------------------------
package done_gated_reset_counter_pkg;

   localparam int unsigned num_stages_default_c = 3;
   localparam int unsigned width_default_c      = 32;

   localparam int unsigned num_stages_max_c     = 16;
   localparam int unsigned width_min_c          = 1;
   localparam int unsigned width_max_c          = 64;

endpackage

// File: rtl/done_gated_reset_counter_reset_delay_chain.sv
// ----------------------------------------------------------------------------
// reset_delay_chain
//   Parameterised flop chain of width_p bits and num_stages_p stages.
//   An asynchronous active-high reset_i presets every stage to preset_p.
//   With num_stages_p = 0 the chain is a plain wire from data_i to data_o,
//   and neither clk_i nor reset_i has any effect.
//
// Ports:
//   clk_i    in   1        clock, rising edge
//   reset_i  in   1        asynchronous preset, active-high
//   data_i   in   width_p  chain input
//   data_o   out  width_p  chain output (data_i delayed num_stages_p cycles)
// ----------------------------------------------------------------------------
module reset_delay_chain #(
   parameter int unsigned          width_p      = 1,
   parameter int unsigned          num_stages_p = 3,
   parameter logic [width_p-1:0]   preset_p     = '1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   if (num_stages_p == 0) begin : g_wire
      logic unused_clk_rst;

      assign unused_clk_rst = clk_i ^ reset_i;
      assign data_o         = data_i;
   end else begin : g_chain
      logic [width_p-1:0] stage_r [num_stages_p];

      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            for (int k = 0; k < int'(num_stages_p); k++) begin
               stage_r[k] <= preset_p;
            end
         end else begin
            stage_r[0] <= data_i;
            for (int k = 1; k < int'(num_stages_p); k++) begin
               stage_r[k] <= stage_r[k-1];
            end
         end
      end

      assign data_o = stage_r[num_stages_p-1];
   end

endmodule

// File: rtl/done_gated_reset_counter.sv
// ----------------------------------------------------------------------------
// done_gated_reset_counter
//   Turns a level "initialisation done" indication into a delayed,
//   active-high downstream reset, and provides a free-running cycle counter
//   that is held at zero while that downstream reset is high.
//
// Ports:
//   clk_i    in   1        the only clock, rising edge
//   reset_i  in   1        asynchronous reset, active-high
//   done_i   in   1        upstream initialisation complete (level)
//   reset_o  out  1        ~done_i delayed by num_stages_p cycles
//   ctr_o    out  width_p  cycles since reset_o was last sampled high
//
// Parameters:
//   num_stages_p  0..16  depth of the done-to-reset delay chain
//   width_p       1..64  counter width
// ----------------------------------------------------------------------------
module done_gated_reset_counter
   import done_gated_reset_counter_pkg::*;
#(
   parameter int unsigned num_stages_p = num_stages_default_c,
   parameter int unsigned width_p      = width_default_c
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               done_i,
   output logic               reset_o,
   output logic [width_p-1:0] ctr_o
);

   logic               reset_dly;
   logic [width_p-1:0] ctr_r;

   // Stages preset to 1 so the downstream reset asserts the moment reset_i
   // does, without waiting for a clock edge.
   reset_delay_chain #(
      .width_p      (1),
      .num_stages_p (num_stages_p),
      .preset_p     (1'b1)
   ) u_reset_delay_chain (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (~done_i),
      .data_o  (reset_dly)
   );

   // The counter looks at the pre-edge reset_o, so the edge on which
   // reset_o falls still loads zero and counting starts one edge later.
   // Wrap at all-ones is silent.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ctr_r <= '0;
      end else if (reset_dly) begin
         ctr_r <= '0;
      end else begin
         ctr_r <= ctr_r + width_p'(1);
      end
   end

   assign reset_o = reset_dly;
   assign ctr_o   = ctr_r;

endmodule

// File: tb/tb_done_gated_reset_counter.sv
module tb_done_gated_reset_counter;

   logic        clk;
   logic        reset;
   logic        done;
   logic        done_w4;
   logic        done_s0;

   logic        reset_o;
   logic [31:0] ctr_o;
   logic        reset_o_w4;
   logic [3:0]  ctr_o_w4;
   logic        reset_o_s0;
   logic [31:0] ctr_o_s0;

   int checks;
   int errors;

   done_gated_reset_counter #(.num_stages_p(3), .width_p(32)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .done_i  (done),
      .reset_o (reset_o),
      .ctr_o   (ctr_o)
   );

   done_gated_reset_counter #(.num_stages_p(3), .width_p(4)) dut_w4 (
      .clk_i   (clk),
      .reset_i (reset),
      .done_i  (done_w4),
      .reset_o (reset_o_w4),
      .ctr_o   (ctr_o_w4)
   );

   done_gated_reset_counter #(.num_stages_p(0), .width_p(32)) dut_s0 (
      .clk_i   (clk),
      .reset_i (reset),
      .done_i  (done_s0),
      .reset_o (reset_o_s0),
      .ctr_o   (ctr_o_s0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and land 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (reset_o !== 1'b1 || ctr_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_async got reset_o=%0b ctr=%0d exp reset_o=1 ctr=0", reset_o, ctr_o);
      end
      checks++;
      if (reset_o_w4 !== 1'b1 || ctr_o_w4 !== 4'd0) begin
         errors++;
         $display("FAIL reset_async_w4 got reset_o=%0b ctr=%0d exp reset_o=1 ctr=0", reset_o_w4, ctr_o_w4);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (reset_o !== 1'b1 || ctr_o !== 32'd0 || reset_o_s0 !== 1'b1 || ctr_o_s0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got reset_o=%0b ctr=%0d s0_reset_o=%0b s0_ctr=%0d exp 1 0 1 0",
                     i, reset_o, ctr_o, reset_o_s0, ctr_o_s0);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (reset_o !== 1'b1 || ctr_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_release cyc=%0d got reset_o=%0b ctr=%0d exp reset_o=1 ctr=0", i, reset_o, ctr_o);
         end
      end
   endtask

   task automatic test_latency();
      logic        exp_rst;
      logic [31:0] exp_ctr;
      done = 1'b1;
      for (int n = 1; n <= 103; n++) begin
         tick();
         exp_rst = (n < 3) ? 1'b1 : 1'b0;
         exp_ctr = (n < 3) ? 32'd0 : 32'(n - 3);
         checks++;
         if (reset_o !== exp_rst || ctr_o !== exp_ctr) begin
            errors++;
            $display("FAIL latency E%0d got reset_o=%0b ctr=%0d exp reset_o=%0b ctr=%0d",
                     n, reset_o, ctr_o, exp_rst, exp_ctr);
         end
      end
   endtask

   task automatic test_wrap();
      logic       exp_rst;
      logic [3:0] exp_ctr;
      done_w4 = 1'b1;
      for (int n = 1; n <= 22; n++) begin
         tick();
         exp_rst = (n < 3) ? 1'b1 : 1'b0;
         exp_ctr = (n < 3) ? 4'd0 : 4'((n - 3) % 16);
         checks++;
         if (reset_o_w4 !== exp_rst || ctr_o_w4 !== exp_ctr) begin
            errors++;
            $display("FAIL wrap_w4 E%0d got reset_o=%0b ctr=%0d exp reset_o=%0b ctr=%0d",
                     n, reset_o_w4, ctr_o_w4, exp_rst, exp_ctr);
         end
      end
   endtask

   task automatic test_done_fall();
      logic        exp_rst [5];
      logic [31:0] exp_ctr [5];
      // Bring the counter to a known value: clear, then count to 50.
      done = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         tick();
         checks++;
         if (reset_o !== (n == 3)) begin
            errors++;
            $display("FAIL fall_prep E%0d got reset_o=%0b exp %0b", n, reset_o, (n == 3));
         end
      end
      tick();
      checks++;
      if (ctr_o !== 32'd0) begin
         errors++;
         $display("FAIL fall_prep_clear got ctr=%0d exp 0", ctr_o);
      end
      done = 1'b1;
      for (int n = 1; n <= 53; n++) tick();
      checks++;
      if (reset_o !== 1'b0 || ctr_o !== 32'd50) begin
         errors++;
         $display("FAIL fall_at50 got reset_o=%0b ctr=%0d exp reset_o=0 ctr=50", reset_o, ctr_o);
      end
      exp_rst = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_ctr = '{32'd51, 32'd52, 32'd53, 32'd0, 32'd0};
      done = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++;
         if (reset_o !== exp_rst[n] || ctr_o !== exp_ctr[n]) begin
            errors++;
            $display("FAIL done_fall F%0d got reset_o=%0b ctr=%0d exp reset_o=%0b ctr=%0d",
                     n + 1, reset_o, ctr_o, exp_rst[n], exp_ctr[n]);
         end
      end
   endtask

   task automatic test_pulse();
      logic        exp_rst [5];
      logic [31:0] exp_ctr [5];
      exp_rst = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      exp_ctr = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
      done = 1'b1;
      tick();
      done = 1'b0;
      for (int n = 0; n < 5; n++) begin
         if (n > 0) tick();
         checks++;
         if (reset_o !== exp_rst[n] || ctr_o !== exp_ctr[n]) begin
            errors++;
            $display("FAIL pulse G%0d got reset_o=%0b ctr=%0d exp reset_o=%0b ctr=%0d",
                     n + 1, reset_o, ctr_o, exp_rst[n], exp_ctr[n]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic        exp_rst [5];
      logic [31:0] exp_ctr [5];
      exp_rst = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_ctr = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2};
      done = 1'b1;
      for (int n = 0; n < 10; n++) tick();
      checks++;
      if (reset_o !== 1'b0 || ctr_o !== 32'd7) begin
         errors++;
         $display("FAIL async_precount got reset_o=%0b ctr=%0d exp reset_o=0 ctr=7", reset_o, ctr_o);
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (reset_o !== 1'b1 || ctr_o !== 32'd0) begin
         errors++;
         $display("FAIL async_assert got reset_o=%0b ctr=%0d exp reset_o=1 ctr=0", reset_o, ctr_o);
      end
      checks++;
      if (reset_o_w4 !== 1'b1 || ctr_o_w4 !== 4'd0) begin
         errors++;
         $display("FAIL async_assert_w4 got reset_o=%0b ctr=%0d exp reset_o=1 ctr=0", reset_o_w4, ctr_o_w4);
      end
      checks++;
      if (reset_o_s0 !== ~done_s0) begin
         errors++;
         $display("FAIL async_s0_passthru got reset_o=%0b exp %0b", reset_o_s0, ~done_s0);
      end
      tick();
      checks++;
      if (reset_o !== 1'b1 || ctr_o !== 32'd0) begin
         errors++;
         $display("FAIL async_hold got reset_o=%0b ctr=%0d exp reset_o=1 ctr=0", reset_o, ctr_o);
      end
      reset = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++;
         if (reset_o !== exp_rst[n] || ctr_o !== exp_ctr[n]) begin
            errors++;
            $display("FAIL async_restart H%0d got reset_o=%0b ctr=%0d exp reset_o=%0b ctr=%0d",
                     n + 1, reset_o, ctr_o, exp_rst[n], exp_ctr[n]);
         end
      end
   endtask

   task automatic test_no_stages();
      done_s0 = 1'b1;
      #1;
      checks++;
      if (reset_o_s0 !== 1'b0 || ctr_o_s0 !== 32'd0) begin
         errors++;
         $display("FAIL s0_comb_fall got reset_o=%0b ctr=%0d exp reset_o=0 ctr=0", reset_o_s0, ctr_o_s0);
      end
      for (int n = 1; n <= 3; n++) begin
         tick();
         checks++;
         if (ctr_o_s0 !== 32'(n)) begin
            errors++;
            $display("FAIL s0_count E%0d got ctr=%0d exp %0d", n, ctr_o_s0, n);
         end
      end
      #3;
      done_s0 = 1'b0;
      #1;
      checks++;
      if (reset_o_s0 !== 1'b1 || ctr_o_s0 !== 32'd3) begin
         errors++;
         $display("FAIL s0_comb_rise got reset_o=%0b ctr=%0d exp reset_o=1 ctr=3", reset_o_s0, ctr_o_s0);
      end
      tick();
      checks++;
      if (ctr_o_s0 !== 32'd0) begin
         errors++;
         $display("FAIL s0_clear got ctr=%0d exp 0", ctr_o_s0);
      end
      tick();
      checks++;
      if (ctr_o_s0 !== 32'd0 || reset_o_s0 !== 1'b1) begin
         errors++;
         $display("FAIL s0_held got reset_o=%0b ctr=%0d exp reset_o=1 ctr=0", reset_o_s0, ctr_o_s0);
      end
      done_s0 = 1'b1;
      tick();
      checks++;
      if (ctr_o_s0 !== 32'd1 || reset_o_s0 !== 1'b0) begin
         errors++;
         $display("FAIL s0_recount got reset_o=%0b ctr=%0d exp reset_o=0 ctr=1", reset_o_s0, ctr_o_s0);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b0;
      done    = 1'b0;
      done_w4 = 1'b0;
      done_s0 = 1'b0;

      test_reset();
      test_latency();
      test_wrap();
      test_done_fall();
      test_pulse();
      test_async_reset();
      test_no_stages();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/done_gated_reset_counter.md
Name: done_gated_reset_counter

Overview:
- Converts a level "initialisation done" indication into a delayed, active-high downstream reset.
- Provides a free-running global cycle counter that is held at zero while that downstream reset is asserted.
- Sits at testbench/SoC top level between the configuration logic (tag programming) and the host/loader logic and profilers.
- Fully synthesizable; single clock domain.

Parameters:
- num_stages_p, 3, depth of the done-to-reset delay chain (allowed range 0..16).
- width_p, 32, cycle counter width in bits (allowed range 1..64).

Ports:
- clk_i  input  1  the only clock; all state updates on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- done_i  input  1  level signal; high means upstream initialisation is complete.
- reset_o  output  1  delayed downstream reset, active-high; equals ~done_i delayed by num_stages_p cycles.
- ctr_o  output  width_p  cycle count since reset_o was last sampled high.

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is asynchronous and active-high.
- While reset_i is high:
  - Every delay-chain stage is forced to 1, so reset_o = 1 immediately, with no clock needed.
  - ctr_o = 0.
- Delay chain, on each rising edge with reset_i low:
  - stage[0] <= ~done_i.
  - stage[k] <= stage[k-1] for k = 1..num_stages_p-1.
  - reset_o = stage[num_stages_p-1].
- num_stages_p = 0: reset_o = ~done_i combinationally, with no storage, and reset_i has no effect on reset_o.
- Counter, on each rising edge with reset_i low:
  - If reset_o is 1, ctr_o <= 0.
  - Otherwise ctr_o <= ctr_o + 1, modulo 2^width_p, so all-ones wraps to 0 silently with no flag.
  - The counter samples registered reset_o, not done_i.
- Latency, with done_i rising before edge E1 and staying high (num_stages_p = 3):
  - reset_o falls after E3.
  - ctr_o is 0 after E3, 1 after E4, and n-3 after edge En.
- done_i falling (done_i low before edge Ej):
  - reset_o rises after edge Ej+num_stages_p-1.
  - ctr_o clears to 0 at the following edge and stays 0 while reset_o is high.
- Pulses on done_i shorter than one cycle are ignored unless sampled. A one-cycle high pulse produces a one-cycle low pulse on reset_o, num_stages_p cycles later.
- reset_i asserted mid-count: ctr_o -> 0 and reset_o -> 1 asynchronously.
- After reset_i deasserts, the chain refills from done_i. If done_i is already high, reset_o falls after num_stages_p edges.
- Simultaneous reset_o fall and counter update: the counter uses the pre-edge reset_o value.
- No X propagation: all outputs are defined from the first edge of reset_i.

Decomposition:
- No shared package needed; there are no typedefs.
- One sub-module: reset_delay_chain, a parameterised width/stage flop chain with an async preset value.
  - Instantiated with width 1, preset 1.
  - Handles num_stages_p = 0 as a wire-through.
- Counter logic lives in the top module.

Test Plan:
1. Hold done_i = 0 and pulse reset_i for 16 cycles, then release -> reset_o = 1 and ctr_o = 0 for all cycles; reset_o goes 1 within the reset_i pulse without any clock edge.
2. Raise done_i before E1 (num_stages_p = 3) -> reset_o falls after E3; ctr_o reads 0, 1, 2, 3 after E3, E4, E5, E6; after E103 ctr_o = 100.
3. width_p = 4 and done_i high long enough -> ctr_o counts 14, 15, 0, 1 across the wrap, with no other output change.
4. Drop done_i to 0 while ctr_o = 50 -> reset_o rises after the 3rd subsequent edge, and ctr_o is 0 on the next edge and held there.
5. Assert reset_i asynchronously mid-cycle while counting -> reset_o = 1 and ctr_o = 0 immediately. After release with done_i = 1, reset_o falls after 3 edges and counting restarts from 0.
6. num_stages_p = 0 -> reset_o tracks ~done_i combinationally; the counter clears on the first edge where done_i = 0 and increments otherwise.
